// File: rtl/multi_edge_detect.sv
// Multi-channel synchronised, debounced edge detector.
// Each channel reports pulses, a sticky flag and a saturating event count.
module multi_edge_detect #(
  parameter int WIDTH       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int DB_CYCLES   = 4,
  parameter int CNT_W       = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [WIDTH-1:0]       in,
  input  logic [2*WIDTH-1:0]     mode,
  input  logic [WIDTH-1:0]       clr,
  output logic [WIDTH-1:0]       level,
  output logic [WIDTH-1:0]       pulse,
  output logic [WIDTH-1:0]       sticky,
  output logic [WIDTH*CNT_W-1:0] count,
  output logic                   any
);

  localparam int DB_W = (DB_CYCLES < 2) ? 1 : $clog2(DB_CYCLES + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    logic [SYNC_STAGES-1:0] s;
    logic [DB_W-1:0]        db_cnt;
    logic [CNT_W-1:0]       ev_cnt;
    logic                   lvl;
    logic                   pls;
    logic                   stk;
    logic                   synced;
    logic                   accept;
    logic                   hit;

    assign synced = s[SYNC_STAGES-1];
    assign accept = (synced != lvl) && (db_cnt == DB_LAST);
    // The edge direction is the incoming synced value at acceptance.
    assign hit = accept &&
                 ((synced && mode[2*i]) || (!synced && mode[2*i+1]));

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        s      <= '0;
        db_cnt <= '0;
        lvl    <= 1'b0;
        pls    <= 1'b0;
      end else begin
        s   <= {s[SYNC_STAGES-2:0], in[i]};
        pls <= hit;
        if (synced == lvl) begin
          db_cnt <= '0;
        end else if (accept) begin
          lvl    <= synced;
          db_cnt <= '0;
        end else begin
          db_cnt <= db_cnt + DB_W'(1);
        end
      end
    end

    // A pulse on the same edge as clr wins over the clear.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        stk    <= 1'b0;
        ev_cnt <= '0;
      end else begin
        if (hit)
          stk <= 1'b1;
        else if (clr[i])
          stk <= 1'b0;
        if (clr[i])
          ev_cnt <= hit ? CNT_W'(1) : '0;
        else if (hit && (ev_cnt != '1))
          ev_cnt <= ev_cnt + CNT_W'(1);
      end
    end

    assign level[i]                  = lvl;
    assign pulse[i]                  = pls;
    assign sticky[i]                 = stk;
    assign count[i*CNT_W +: CNT_W]   = ev_cnt;
  end

  assign any = |pulse;

endmodule

// File: tb/tb_multi_edge_detect.sv
// Directed vector bench for multi_edge_detect.
// Table of per-edge vectors plus hand-written multi-cycle sequences.
module tb_multi_edge_detect;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  in = '0;
  logic [7:0]  mode = '0;
  logic [3:0]  clr = '0;
  logic [3:0]  level, pulse, sticky;
  logic [31:0] count;
  logic        any;

  logic [3:0]  s_in = '0;
  logic [7:0]  s_mode = '0;
  logic [3:0]  s_clr = '0;
  logic [3:0]  s_level, s_pulse, s_sticky;
  logic [7:0]  s_count;
  logic        s_any;

  int tests = 0;
  int failed = 0;

  multi_edge_detect u_dut (
    .clk(clk), .reset(reset), .in(in), .mode(mode), .clr(clr),
    .level(level), .pulse(pulse), .sticky(sticky),
    .count(count), .any(any)
  );

  multi_edge_detect #(.CNT_W(2)) u_sat (
    .clk(clk), .reset(reset), .in(s_in), .mode(s_mode), .clr(s_clr),
    .level(s_level), .pulse(s_pulse), .sticky(s_sticky),
    .count(s_count), .any(s_any)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  in;
    logic [7:0]  mode;
    logic [3:0]  clr;
    logic [3:0]  level;
    logic [3:0]  pulse;
    logic [3:0]  sticky;
    logic        any;
    logic [31:0] count;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic [3:0] i, input logic [7:0] m,
                     input logic [3:0] c, input logic [3:0] l,
                     input logic [3:0] p, input logic [3:0] st,
                     input logic a, input logic [31:0] cn);
    vec_t v;
    v.in = i; v.mode = m; v.clr = c; v.level = l;
    v.pulse = p; v.sticky = st; v.any = a; v.count = cn;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".level"}, 32'(level), 32'h0);
    chk({tag, ".pulse"}, 32'(pulse), 32'h0);
    chk({tag, ".sticky"}, 32'(sticky), 32'h0);
    chk({tag, ".count"}, count, 32'h0);
    chk({tag, ".any"}, 32'(any), 32'h0);
  endtask

  task automatic edge_seq(input string tag, input logic [7:0] m,
                          input int e1, input int e2,
                          input logic [31:0] expc);
    in = '0; clr = '0;
    do_reset();
    mode = m;
    for (int e = 1; e <= 32; e++) begin
      in = (e <= 20) ? 4'b0100 : 4'b0000;
      step();
      chk($sformatf("%s.pulse@%0d", tag, e), 32'(pulse),
          (e == e1 || e == e2) ? 32'h4 : 32'h0);
    end
    chk({tag, ".count"}, count, expc);
  endtask

  initial begin
    for (int k = 0; k < 5; k++) add(4'b0001, 8'h55, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 32'h0);
    add(4'b0001, 8'h55, 4'h0, 4'h1, 4'h1, 4'h1, 1'b1, 32'h1);
    add(4'b0001, 8'h55, 4'h0, 4'h1, 4'h0, 4'h1, 1'b0, 32'h1);
    for (int k = 0; k < 3; k++) add(4'b0011, 8'h55, 4'h0, 4'h1, 4'h0, 4'h1, 1'b0, 32'h1);
    for (int k = 0; k < 7; k++) add(4'b0001, 8'h55, 4'h0, 4'h1, 4'h0, 4'h1, 1'b0, 32'h1);
    add(4'b0001, 8'h55, 4'h1, 4'h1, 4'h0, 4'h0, 1'b0, 32'h0);
    add(4'b0001, 8'h55, 4'h0, 4'h1, 4'h0, 4'h0, 1'b0, 32'h0);
    for (int k = 0; k < 5; k++) add(4'b0101, 8'h45, 4'h0, 4'h1, 4'h0, 4'h0, 1'b0, 32'h0);
    add(4'b0101, 8'h45, 4'h0, 4'h5, 4'h0, 4'h0, 1'b0, 32'h0);
    add(4'b0101, 8'h45, 4'h0, 4'h5, 4'h0, 4'h0, 1'b0, 32'h0);
    add(4'b0101, 8'h55, 4'h0, 4'h5, 4'h0, 4'h0, 1'b0, 32'h0);
    add(4'b0101, 8'h55, 4'h0, 4'h5, 4'h0, 4'h0, 1'b0, 32'h0);

    // Reset state
    do_reset();
    chk_all_zero("reset");
    chk("reset.sat_count", 32'(s_count), 32'h0);

    // Table-driven run from reset release
    foreach (vecs[i]) begin
      in = vecs[i].in; mode = vecs[i].mode; clr = vecs[i].clr;
      step();
      chk($sformatf("vec%0d.level", i), 32'(level), 32'(vecs[i].level));
      chk($sformatf("vec%0d.pulse", i), 32'(pulse), 32'(vecs[i].pulse));
      chk($sformatf("vec%0d.sticky", i), 32'(sticky), 32'(vecs[i].sticky));
      chk($sformatf("vec%0d.any", i), 32'(any), 32'(vecs[i].any));
      chk($sformatf("vec%0d.count", i), count, vecs[i].count);
    end
    clr = '0;

    // Channel 2 both edges, then falling only
    edge_seq("both", 8'h30, 6, 26, 32'h0002_0000);
    edge_seq("fall", 8'h20, -1, 26, 32'h0001_0000);

    // Saturating counter with CNT_W=2
    in = '0; s_in = '0; s_clr = '0; s_mode = 8'h55;
    do_reset();
    for (int k = 0; k < 5; k++) begin
      s_in = 4'b0001;
      repeat (8) step();
      chk($sformatf("sat.count%0d", k), 32'(s_count[1:0]),
          (k < 3) ? 32'(k + 1) : 32'h3);
      s_in = 4'b0000;
      repeat (8) step();
    end
    s_in = 4'b0001;
    repeat (5) step();
    chk("sat.pre_clr", 32'(s_count[1:0]), 32'h3);
    s_clr = 4'b0001;
    step();
    s_clr = 4'b0000;
    chk("sat.clr_pulse", 32'(s_pulse[0]), 32'h1);
    chk("sat.clr_count", 32'(s_count[1:0]), 32'h1);
    chk("sat.clr_sticky", 32'(s_sticky[0]), 32'h1);
    s_in = '0;

    // Simultaneous channels, then reset mid-debounce
    in = '0; mode = 8'hFF;
    do_reset();
    in = 4'b1001;
    for (int e = 1; e <= 7; e++) begin
      step();
      chk($sformatf("multi.pulse@%0d", e), 32'(pulse),
          (e == 6) ? 32'h9 : 32'h0);
      chk($sformatf("multi.any@%0d", e), 32'(any),
          (e == 6) ? 32'h1 : 32'h0);
    end
    chk("multi.count", count, 32'h0100_0001);
    in = 4'b0000;
    step();
    step();
    reset = 1'b1;
    #1;
    chk_all_zero("async_reset");
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
    for (int e = 1; e <= 12; e++) begin
      step();
      chk($sformatf("post_reset.pulse@%0d", e), 32'(pulse), 32'h0);
      chk($sformatf("post_reset.level@%0d", e), 32'(level), 32'h0);
    end

    // Input held high through reset
    in = 4'b0001; mode = 8'h55;
    do_reset();
    for (int e = 1; e <= 8; e++) begin
      step();
      chk($sformatf("held.pulse@%0d", e), 32'(pulse),
          (e == 6) ? 32'h1 : 32'h0);
    end
    chk("held.level", 32'(level), 32'h1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
